// File: rtl/bp_update_ctrl_if.sv
// Update-side bundle between EX branch resolution, bp_update_ctrl and the predictor tables.
// slave = controller view, master = driver/monitor view.
interface bp_update_ctrl_if #(
    parameter int PHT_INDEX_BITS = 10,
    parameter int BHT_INDEX_BITS = 3
);
    logic                      upd_valid_i;
    logic [BHT_INDEX_BITS-1:0] upd_bht_index_i;
    logic [PHT_INDEX_BITS-1:0] upd_pht_index_i;
    logic                      upd_actually_taken_i;
    logic                      upd_predict_result_i;
    logic                      upd_hold_i;
    logic                      flush_tables_i;

    logic                      pred_upd_en_o;
    logic [BHT_INDEX_BITS-1:0] pred_bht_index_o;
    logic [PHT_INDEX_BITS-1:0] pred_pht_index_o;
    logic                      pred_actually_taken_o;
    logic                      pred_predict_result_o;
    logic                      init_pht_we_o;
    logic                      init_bht_we_o;
    logic [PHT_INDEX_BITS-1:0] init_index_o;
    logic                      ready_o;
    logic                      fifo_full_o;
    logic [15:0]               stat_accept_cnt_o;
    logic [15:0]               stat_drop_cnt_o;

    modport slave (
        input  upd_valid_i, upd_bht_index_i, upd_pht_index_i, upd_actually_taken_i,
               upd_predict_result_i, upd_hold_i, flush_tables_i,
        output pred_upd_en_o, pred_bht_index_o, pred_pht_index_o, pred_actually_taken_o,
               pred_predict_result_o, init_pht_we_o, init_bht_we_o, init_index_o,
               ready_o, fifo_full_o, stat_accept_cnt_o, stat_drop_cnt_o
    );

    modport master (
        output upd_valid_i, upd_bht_index_i, upd_pht_index_i, upd_actually_taken_i,
               upd_predict_result_i, upd_hold_i, flush_tables_i,
        input  pred_upd_en_o, pred_bht_index_o, pred_pht_index_o, pred_actually_taken_o,
               pred_predict_result_o, init_pht_we_o, init_bht_we_o, init_index_o,
               ready_o, fifo_full_o, stat_accept_cnt_o, stat_drop_cnt_o
    );
endinterface

// File: rtl/bp_update_ctrl.sv
// Branch predictor write sequencer: table init sweep, then FIFO-buffered training updates (2-cycle min latency;
// upd_upd_hold_i stalls dequeue only, overflow drops). Optional saturating counters under BP_UPD_STATS_EN.
module bp_update_ctrl #(
    parameter int PHT_INDEX_BITS = 10,
    parameter int BHT_INDEX_BITS = 3,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic clk,
    input  logic rst,
    bp_update_ctrl_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]            PTR_ONE   = 1;
    localparam logic [PHT_INDEX_BITS-1:0] INDEX_ONE = 1;

    typedef struct packed {
        logic [BHT_INDEX_BITS-1:0] bht;
        logic [PHT_INDEX_BITS-1:0] pht;
        logic                      taken;
        logic                      result;
    } upd_t;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                    r_state, w_state_nxt;
    logic [PHT_INDEX_BITS-1:0] r_index, w_index_nxt;
    logic                      w_init_pht_we, w_init_bht_we;

    upd_t                      r_fifo [FIFO_DEPTH];
    logic [PTR_W:0]            r_wr_ptr, r_rd_ptr;
    logic                      w_empty, w_full;
    logic                      w_run, w_flush, w_enq, w_deq;
    logic                      w_bht_in_range;
    upd_t                      w_in;

    logic                      r_pred_en;
    upd_t                      r_pred;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                     (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);

    assign w_run   = (r_state == ST_RUN);
    assign w_flush = w_run && bus.flush_tables_i;
    // A flush cycle neither issues nor accepts, so nothing leaks past the re-init.
    assign w_deq   = w_run && !bus.flush_tables_i && !w_empty && !bus.upd_hold_i;
    assign w_enq   = w_run && !bus.flush_tables_i && bus.upd_valid_i && (!w_full || w_deq);

    assign w_bht_in_range = ((r_index >> BHT_INDEX_BITS) == '0);

    assign w_in = '{bht:    bus.upd_bht_index_i,
                    pht:    bus.upd_pht_index_i,
                    taken:  bus.upd_actually_taken_i,
                    result: bus.upd_predict_result_i};

    always_comb begin
        w_state_nxt   = r_state;
        w_index_nxt   = r_index;
        w_init_pht_we = 1'b0;
        w_init_bht_we = 1'b0;
        case (r_state)
            ST_INIT: begin
                w_init_pht_we = 1'b1;
                w_init_bht_we = w_bht_in_range;
                if (r_index == '1) begin
                    w_state_nxt = ST_RUN;
                    w_index_nxt = '0;
                end else begin
                    w_index_nxt = r_index + INDEX_ONE;
                end
            end
            ST_RUN: begin
                if (bus.flush_tables_i) begin
                    w_state_nxt = ST_INIT;
                    w_index_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = ST_INIT;
                w_index_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_INIT;
            r_index   <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_pred_en <= 1'b0;
            r_pred    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_index   <= w_index_nxt;
            r_pred_en <= w_deq;
            if (w_deq) begin
                r_pred <= r_fifo[r_rd_ptr[PTR_W-1:0]];
            end
            if (w_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_enq) r_wr_ptr <= r_wr_ptr + PTR_ONE;
                if (w_deq) r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
        end
    end

    // Storage needs no reset: occupancy is defined purely by the pointers.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_fifo[r_wr_ptr[PTR_W-1:0]] <= w_in;
        end
    end

    assign bus.pred_upd_en_o         = r_pred_en;
    assign bus.pred_bht_index_o      = r_pred.bht;
    assign bus.pred_pht_index_o      = r_pred.pht;
    assign bus.pred_actually_taken_o = r_pred.taken;
    assign bus.pred_predict_result_o = r_pred.result;
    assign bus.init_pht_we_o         = w_init_pht_we;
    assign bus.init_bht_we_o         = w_init_bht_we;
    assign bus.init_index_o          = r_index;
    assign bus.ready_o               = w_run;
    assign bus.fifo_full_o           = w_full;

`ifdef BP_UPD_STATS_EN
    logic        w_drop;
    logic [15:0] r_accept_cnt, r_drop_cnt;

    assign w_drop = bus.upd_valid_i && !w_enq;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_accept_cnt <= '0;
            r_drop_cnt   <= '0;
        end else begin
            if (w_enq && (r_accept_cnt != 16'hFFFF)) r_accept_cnt <= r_accept_cnt + 16'd1;
            if (w_drop && (r_drop_cnt != 16'hFFFF))  r_drop_cnt   <= r_drop_cnt + 16'd1;
        end
    end

    assign bus.stat_accept_cnt_o = r_accept_cnt;
    assign bus.stat_drop_cnt_o   = r_drop_cnt;
`else
    assign bus.stat_accept_cnt_o = '0;
    assign bus.stat_drop_cnt_o   = '0;
`endif
endmodule

// File: tb/tb_bp_update_ctrl.sv
// Scoreboard bench for bp_update_ctrl: directed stimulus pushes expected strobes, a negedge monitor pops and compares.
module tb_bp_update_ctrl;
    localparam int PHT   = 10;
    localparam int BHT   = 3;
    localparam int DEPTH = 4;
    localparam int SWEEP = 1 << PHT;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bp_update_ctrl_if #(.PHT_INDEX_BITS(PHT), .BHT_INDEX_BITS(BHT)) bus();

    bp_update_ctrl #(.PHT_INDEX_BITS(PHT), .BHT_INDEX_BITS(BHT), .FIFO_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [BHT-1:0] bht;
        logic [PHT-1:0] pht;
        logic           tk;
        logic           res;
        int             cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    exp_t pend[$];
    int   cyc = 0;
    int   vectors = 0;
    int   errors = 0;
    int   exp_acc = 0;
    int   exp_drop = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && bus.pred_upd_en_o) begin
            if (sb.size() == 0) begin
                chk("unexpected_strobe", bus.pred_upd_en_o, 1'b0);
            end else begin
                mon_e = sb.pop_front();
                chk("pred_bht", bus.pred_bht_index_o, mon_e.bht);
                chk("pred_pht", bus.pred_pht_index_o, mon_e.pht);
                chk("pred_taken", bus.pred_actually_taken_o, mon_e.tk);
                chk("pred_result", bus.pred_predict_result_o, mon_e.res);
                if (mon_e.cyc >= 0) chk("pred_cycle", cyc, mon_e.cyc);
            end
        end
    end

    task automatic check_stats(input string tag);
`ifdef BP_UPD_STATS_EN
        chk({tag, "_accept"}, bus.stat_accept_cnt_o, exp_acc);
        chk({tag, "_drop"}, bus.stat_drop_cnt_o, exp_drop);
`else
        chk({tag, "_accept"}, bus.stat_accept_cnt_o, 0);
        chk({tag, "_drop"}, bus.stat_drop_cnt_o, 0);
`endif
    endtask

    // Drives one update for a single cycle; returns the cycle it was presented in.
    task automatic send(input int bht, input int pht, input bit tk, input bit res, output int t);
        @(posedge clk); #1;
        bus.upd_valid_i          = 1'b1;
        bus.upd_bht_index_i      = BHT'(bht);
        bus.upd_pht_index_i      = PHT'(pht);
        bus.upd_actually_taken_i = tk;
        bus.upd_predict_result_i = res;
        t = cyc;
    endtask

    task automatic idle();
        @(posedge clk); #1;
        bus.upd_valid_i = 1'b0;
    endtask

    function automatic exp_t mk(input int bht, input int pht, input bit tk, input bit res, input int c);
        exp_t e;
        e.bht = BHT'(bht); e.pht = PHT'(pht); e.tk = tk; e.res = res; e.cyc = c;
        return e;
    endfunction

    task automatic drain(input string tag);
        for (int k = 0; k < 40 && sb.size() != 0; k++) @(posedge clk);
        chk({tag, "_drained"}, sb.size(), 0);
        sb.delete();
        repeat (3) @(posedge clk);
    endtask

    task automatic sweep(input bit inject);
        for (int i = 0; i < SWEEP; i++) begin
            @(negedge clk);
            chk("init_index", bus.init_index_o, i);
            chk("init_pht_we", bus.init_pht_we_o, 1'b1);
            chk("init_bht_we", bus.init_bht_we_o, (i < (1 << BHT)) ? 1'b1 : 1'b0);
            chk("init_ready", bus.ready_o, 1'b0);
            if (inject) begin
                bus.upd_valid_i    = (i == 5);
                bus.upd_hold_i     = (i >= 20 && i < 30);
                bus.flush_tables_i = (i == 40);
                if (i == 5) exp_drop++;
            end
        end
        @(negedge clk);
        chk("run_ready", bus.ready_o, 1'b1);
        chk("run_index", bus.init_index_o, 0);
        chk("run_pht_we", bus.init_pht_we_o, 1'b0);
        chk("run_bht_we", bus.init_bht_we_o, 1'b0);
    endtask

    initial begin
        int t, r;
        bus.upd_valid_i = 1'b0; bus.upd_bht_index_i = '0; bus.upd_pht_index_i = '0;
        bus.upd_actually_taken_i = 1'b0; bus.upd_predict_result_i = 1'b0;
        bus.upd_hold_i = 1'b0; bus.flush_tables_i = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_index", bus.init_index_o, 0);
        chk("rst_pht_we", bus.init_pht_we_o, 1'b1);
        chk("rst_bht_we", bus.init_bht_we_o, 1'b1);
        chk("rst_ready", bus.ready_o, 1'b0);
        chk("rst_pred_en", bus.pred_upd_en_o, 1'b0);
        chk("rst_full", bus.fifo_full_o, 1'b0);
        check_stats("rst");

        @(posedge clk); #1 rst = 1'b0;
        sweep(1'b1);
        check_stats("post_init");

        // Single update: strobe exactly two cycles later.
        send(5, 'h2A3, 1'b1, 1'b1, t);
        sb.push_back(mk(5, 'h2A3, 1'b1, 1'b1, t + 2));
        exp_acc++;
        idle();
        drain("single");

        // Hold with six back-to-back updates: four fill, two drop.
        @(posedge clk); #1 bus.upd_hold_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send(i, 'h100 + i, i[0], ~i[0], t);
            if (i < DEPTH) begin
                pend.push_back(mk(i, 'h100 + i, i[0], ~i[0], 0));
                exp_acc++;
            end else begin
                exp_drop++;
            end
        end
        idle();
        @(negedge clk);
        chk("hold_full", bus.fifo_full_o, 1'b1);
        check_stats("hold");
        @(posedge clk); #1 bus.upd_hold_i = 1'b0;
        r = cyc;
        for (int i = 0; i < DEPTH; i++) begin
            mon_e = pend.pop_front();
            sb.push_back(mk(mon_e.bht, mon_e.pht, mon_e.tk, mon_e.res, r + 1 + i));
        end
        drain("release");
        @(negedge clk);
        chk("release_not_full", bus.fifo_full_o, 1'b0);

        // Full FIFO with an enqueue in the same cycle as a dequeue.
        @(posedge clk); #1 bus.upd_hold_i = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            send(i + 2, 'h300 + i, 1'b1, i[0], t);
            exp_acc++;
        end
        idle();
        @(posedge clk); #1;
        bus.upd_hold_i = 1'b0;
        bus.upd_valid_i = 1'b1; bus.upd_bht_index_i = 3'd7; bus.upd_pht_index_i = PHT'('h3FF);
        bus.upd_actually_taken_i = 1'b0; bus.upd_predict_result_i = 1'b1;
        r = cyc;
        exp_acc++;
        for (int i = 0; i < DEPTH; i++) sb.push_back(mk(i + 2, 'h300 + i, 1'b1, i[0], r + 1 + i));
        sb.push_back(mk(7, 'h3FF, 1'b0, 1'b1, r + 1 + DEPTH));
        idle();
        @(negedge clk);
        chk("simul_full", bus.fifo_full_o, 1'b1);
        check_stats("simul");
        drain("simul");

        // Flush with three queued entries: nothing issues, sweep restarts.
        @(posedge clk); #1 bus.upd_hold_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send(1, 'h050 + i, 1'b0, 1'b0, t);
            exp_acc++;
        end
        @(posedge clk); #1;
        bus.flush_tables_i = 1'b1; bus.upd_hold_i = 1'b0; bus.upd_valid_i = 1'b1;
        exp_drop++;
        @(posedge clk); #1;
        bus.flush_tables_i = 1'b0; bus.upd_valid_i = 1'b0;
        sweep(1'b0);
        chk("flush_not_full", bus.fifo_full_o, 1'b0);
        repeat (10) @(posedge clk);
        check_stats("flush");
        send(2, 'h155, 1'b0, 1'b1, t);
        sb.push_back(mk(2, 'h155, 1'b0, 1'b1, t + 2));
        exp_acc++;
        idle();
        drain("post_flush");

        // Asynchronous reset in the middle of a sweep.
        @(posedge clk); #1 bus.flush_tables_i = 1'b1;
        @(posedge clk); #1 bus.flush_tables_i = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (bus.init_index_o == PHT'(300)) break;
        end
        chk("reach_300", bus.init_index_o, 300);
        #2 rst = 1'b1;
        #1;
        chk("arst_index", bus.init_index_o, 0);
        chk("arst_pht_we", bus.init_pht_we_o, 1'b1);
        chk("arst_bht_we", bus.init_bht_we_o, 1'b1);
        chk("arst_ready", bus.ready_o, 1'b0);
        exp_acc = 0;
        exp_drop = 0;
        check_stats("arst");
        @(posedge clk); #1 rst = 1'b0;
        sweep(1'b0);
        send(6, 'h2A3, 1'b1, 1'b0, t);
        sb.push_back(mk(6, 'h2A3, 1'b1, 1'b0, t + 2));
        exp_acc++;
        idle();
        drain("post_arst");
        check_stats("final");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/bp_update_ctrl.md
Name: bp_update_ctrl

Overview:
- Sequencer that owns the write side of the local branch predictor (BHT + PHT).
- After reset or a table-flush request, performs a one-entry-per-cycle initialisation sweep of both tables, replacing the per-cycle for-loop reset.
- In normal operation, buffers resolved-branch training updates from Execute in a small FIFO and issues them to the predictor update port, one per cycle, when the port is not held.
- Sits between the EX-stage branch resolution logic and the predictor tables.

Parameters:
- PHT_INDEX_BITS, 10, PHT index width; PHT has 2^PHT_INDEX_BITS 2-bit counters.
- BHT_INDEX_BITS, 3, BHT index width; must be <= PHT_INDEX_BITS.
- FIFO_DEPTH, 4, update buffer entries; power of two, >= 2.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- upd_valid_i  in  1  resolved branch update from Execute.
- upd_bht_index_i  in  BHT_INDEX_BITS  BHT entry to shift.
- upd_pht_index_i  in  PHT_INDEX_BITS  PHT entry to train.
- upd_actually_taken_i  in  1  resolved direction, shifted into BHR.
- upd_predict_result_i  in  1  PHT training direction.
- upd_hold_i  in  1  predictor write port unavailable this cycle.
- flush_tables_i  in  1  request re-initialisation of both tables.
- pred_upd_en_o  out  1  write strobe to predictor (branchE).
- pred_bht_index_o  out  BHT_INDEX_BITS  BHT index for the update.
- pred_pht_index_o  out  PHT_INDEX_BITS  PHT index for the update.
- pred_actually_taken_o  out  1  direction for the update.
- pred_predict_result_o  out  1  training direction for the update.
- init_pht_we_o  out  1  PHT init write; value written is weakly_taken.
- init_bht_we_o  out  1  BHT init write; value written is 0.
- init_index_o  out  PHT_INDEX_BITS  sweep index; BHT uses the low BHT_INDEX_BITS bits.
- ready_o  out  1  1 only in RUN; frontend must treat predictions as not-taken while 0.
- fifo_full_o  out  1  update FIFO full.
- stat_accept_cnt_o  out  16  accepted updates (optional feature).
- stat_drop_cnt_o  out  16  dropped updates (optional feature).

Behaviour:
- Reset values (async on rst): state=INIT, init_index_o=0, FIFO empty, counters 0. All other outputs are 0 except init_pht_we_o=1 and init_bht_we_o=1, which are driven combinationally from INIT state with index 0.
- INIT state:
  - init_pht_we_o=1 every cycle.
  - init_bht_we_o=1 while init_index_o < 2^BHT_INDEX_BITS.
  - init_index_o increments by 1 per cycle.
  - After the cycle with index 2^PHT_INDEX_BITS-1, go to RUN and reset index to 0. The sweep lasts exactly 2^PHT_INDEX_BITS cycles.
  - upd_valid_i is dropped; the drop counter increments.
  - pred_upd_en_o=0. flush_tables_i is ignored. upd_hold_i does not stall the sweep.
- RUN state:
  - ready_o=1.
  - Enqueue when upd_valid_i and (not full, or a dequeue happens in the same cycle).
  - Dequeue when FIFO non-empty and !upd_hold_i.
  - pred_* outputs are registered: the dequeued head appears on pred_* the cycle after the dequeue decision, with pred_upd_en_o=1 for exactly one cycle.
  - Minimum latency from upd_valid_i to pred_upd_en_o is 2 cycles (enqueue, then dequeue).
  - FIFO order is strict; updates to the same index are never merged.
  - Full and no dequeue: the update is dropped; the drop counter increments; fifo_full_o stays 1.
- flush_tables_i in RUN:
  - Next cycle: FIFO cleared, pending pred_upd_en_o suppressed, state=INIT, index=0.
  - An update arriving in the flush cycle is dropped.
- Pointer wrap uses a log2(FIFO_DEPTH)+1-bit read/write pointer pair. full = MSBs differ and LSBs equal.
- upd_hold_i only blocks dequeue; enqueue continues.
- rst asserted at any time, including mid-sweep or mid-drain, returns immediately to the reset values. Buffered updates are lost.

Optional Feature:
- BP_UPD_STATS_EN defined:
  - stat_accept_cnt_o increments on every enqueue.
  - stat_drop_cnt_o increments on every dropped update.
  - Both are 16-bit, saturate at 0xFFFF, and are cleared only by rst (not by flush).
- Not defined: both outputs are tied to 0 and no counter flops exist.

Test Plan:
- Reset with PHT_INDEX_BITS=10, BHT_INDEX_BITS=3 -> init_pht_we_o=1 for 1024 cycles with index 0..1023; init_bht_we_o=1 only for indices 0..7; ready_o rises on cycle 1024.
- RUN, single update (bht=5, pht=0x2A3, taken=1, result=1) at cycle T -> pred_upd_en_o=1 at T+2 only, with identical fields.
- upd_hold_i=1, then 6 back-to-back updates with FIFO_DEPTH=4 -> first 4 accepted, fifo_full_o=1, last 2 dropped (drop count 2 with the macro). Release hold -> 4 strobes on consecutive cycles in FIFO order.
- FIFO full, hold=0, new update in the same cycle as a dequeue -> update accepted, no drop, fifo_full_o stays 1.
- flush_tables_i with 3 entries queued -> no further pred_upd_en_o; INIT sweep restarts at index 0; ready_o=0 for 1024 cycles.
- rst asserted mid-sweep at index 300 -> index returns to 0 asynchronously; sweep restarts from 0 after rst deasserts.
